// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU and condition function codes,
// condition-code bit positions and the branch/cmov condition evaluator.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] ALUADD = 4'h0;
  localparam logic [3:0] ALUSUB = 4'h1;
  localparam logic [3:0] ALUAND = 4'h2;
  localparam logic [3:0] ALUXOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // Unknown condition codes evaluate false; the caller flags them as illegal.
  function automatic logic condHolds(input logic [2:0] cc, input logic [3:0] ifun);
    logic zf, sf, of;
    zf = cc[CC_ZF];
    sf = cc[CC_SF];
    of = cc[CC_OF];
    case (ifun)
      C_YES:   condHolds = 1'b1;
      C_LE:    condHolds = (sf ^ of) | zf;
      C_L:     condHolds = sf ^ of;
      C_E:     condHolds = zf;
      C_NE:    condHolds = ~zf;
      C_GE:    condHolds = ~(sf ^ of);
      C_G:     condHolds = ~(sf ^ of) & ~zf;
      default: condHolds = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu.sv
// OPq arithmetic/logic unit: result is always b OP a, with Y86 flag semantics
// and an illegal flag for function codes outside add/sub/and/xor.
module y86_alu #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [3:0]   i_ifun,
  output logic [W-1:0] o_result,
  output logic         o_zf,
  output logic         o_sf,
  output logic         o_of,
  output logic         o_illegal
);
  import y86_pkg::*;

  always_comb begin
    o_result  = '0;
    o_of      = 1'b0;
    o_illegal = 1'b0;
    case (i_ifun)
      ALUADD: begin
        o_result = i_b + i_a;
        o_of     = (i_a[W-1] == i_b[W-1]) && (o_result[W-1] != i_b[W-1]);
      end
      ALUSUB: begin
        o_result = i_b - i_a;
        o_of     = (i_a[W-1] != i_b[W-1]) && (o_result[W-1] != i_b[W-1]);
      end
      ALUAND:  o_result = i_b & i_a;
      ALUXOR:  o_result = i_b ^ i_a;
      default: o_illegal = 1'b1;
    endcase
    o_zf = (o_result == '0);
    o_sf = o_result[W-1];
  end

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: computes valE and the branch/cmov condition, owns the
// condition-code register and drives the E/M pipeline register with stall/bubble.
module y86_execute_stage #(
  parameter int         W          = 64,
  parameter int         STACK_STEP = W / 8,
  parameter logic [3:0] RNONE      = y86_pkg::RNONE
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_instr_valid,
  input  logic         i_stall,
  input  logic         i_bubble,
  input  logic         i_set_cc_en,
  input  logic [3:0]   i_icode,
  input  logic [3:0]   i_ifun,
  input  logic [W-1:0] i_valA,
  input  logic [W-1:0] i_valB,
  input  logic [W-1:0] i_valC,
  input  logic [3:0]   i_dstE_in,
  input  logic [3:0]   i_dstM_in,
  output logic         o_m_valid,
  output logic [3:0]   o_m_icode,
  output logic [W-1:0] o_m_valE,
  output logic [W-1:0] o_m_valA,
  output logic         o_m_cnd,
  output logic [3:0]   o_m_dstE,
  output logic [3:0]   o_m_dstM,
  output logic         o_m_err,
  output logic [2:0]   o_cc
);
  import y86_pkg::*;

  localparam logic [W-1:0] STEP = W'(STACK_STEP);

  logic         r_valid, r_cnd, r_err;
  logic [3:0]   r_icode, r_dstE, r_dstM;
  logic [W-1:0] r_valE, r_valA;
  logic [2:0]   r_cc;

  logic [W-1:0] w_aluResult, w_valE;
  logic         w_aluZf, w_aluSf, w_aluOf, w_aluIllegal;
  logic         w_cnd, w_illegal, w_ccWrite;
  logic [3:0]   w_dstE, w_dstM;

  y86_alu #(.W(W)) u_alu (
    .i_a       (i_valA),
    .i_b       (i_valB),
    .i_ifun    (i_ifun),
    .o_result  (w_aluResult),
    .o_zf      (w_aluZf),
    .o_sf      (w_aluSf),
    .o_of      (w_aluOf),
    .o_illegal (w_aluIllegal)
  );

  // Condition evaluation deliberately reads r_cc, i.e. flags from before this edge.
  always_comb begin
    w_valE    = '0;
    w_cnd     = 1'b0;
    w_illegal = 1'b0;
    case (i_icode)
      IRRMOVQ, IJXX: begin
        if (i_icode == IRRMOVQ) w_valE = i_valA;
        w_illegal = (i_ifun > C_G);
        w_cnd     = condHolds(r_cc, i_ifun);
      end
      IIRMOVQ:          w_valE = i_valC;
      IRMMOVQ, IMRMOVQ: w_valE = i_valB + i_valC;
      IOPQ: begin
        w_valE    = w_aluResult;
        w_illegal = w_aluIllegal;
      end
      ICALL, IPUSHQ:    w_valE = i_valB - STEP;
      IRET, IPOPQ:      w_valE = i_valB + STEP;
      default: ;
    endcase
    if (w_illegal) begin
      w_valE = '0;
      w_cnd  = 1'b0;
    end
    w_dstE = i_dstE_in;
    if (w_illegal || !i_instr_valid || (i_icode == IRRMOVQ && !w_cnd))
      w_dstE = RNONE;
    w_dstM    = i_instr_valid ? i_dstM_in : RNONE;
    w_ccWrite = (i_icode == IOPQ) && !w_aluIllegal && i_instr_valid &&
                i_set_cc_en && !i_stall && !i_bubble;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_icode <= INOP;
      r_valE  <= '0;
      r_valA  <= '0;
      r_cnd   <= 1'b0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
      r_err   <= 1'b0;
    end else if (i_stall) begin
      r_valid <= r_valid;
    end else if (i_bubble) begin
      r_valid <= 1'b0;
      r_icode <= INOP;
      r_valE  <= '0;
      r_valA  <= '0;
      r_cnd   <= 1'b0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
      r_err   <= 1'b0;
    end else begin
      r_valid <= i_instr_valid;
      r_icode <= i_icode;
      r_valE  <= w_valE;
      r_valA  <= i_valA;
      r_cnd   <= w_cnd;
      r_dstE  <= w_dstE;
      r_dstM  <= w_dstM;
      r_err   <= w_illegal;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_cc <= 3'b100;
    else if (w_ccWrite)
      r_cc <= {w_aluZf, w_aluSf, w_aluOf};
  end

  assign o_m_valid = r_valid;
  assign o_m_icode = r_icode;
  assign o_m_valE  = r_valE;
  assign o_m_valA  = r_valA;
  assign o_m_cnd   = r_cnd;
  assign o_m_dstE  = r_dstE;
  assign o_m_dstM  = r_dstM;
  assign o_m_err   = r_err;
  assign o_cc      = r_cc;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Randomised and directed bench for y86_execute_stage against a behavioural
// model of the execute-stage rules; a second W=16 instance covers narrow overflow.
module tb_y86_execute_stage;
  import y86_pkg::*;

  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstN, instrValid, stall, bubble, setCcEn;
  logic [3:0]   icode, ifun, dstEIn, dstMIn;
  logic [W-1:0] valA, valB, valC;

  logic         mValid, mCnd, mErr;
  logic [3:0]   mIcode, mDstE, mDstM;
  logic [W-1:0] mValE, mValA;
  logic [2:0]   cc;

  logic         s16Valid, s16Cnd, s16Err;
  logic [3:0]   s16Icode, s16DstE, s16DstM;
  logic [15:0]  s16ValE, s16ValA;
  logic [2:0]   s16Cc;

  y86_execute_stage #(.W(W)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_instr_valid(instrValid), .i_stall(stall),
    .i_bubble(bubble), .i_set_cc_en(setCcEn), .i_icode(icode), .i_ifun(ifun),
    .i_valA(valA), .i_valB(valB), .i_valC(valC), .i_dstE_in(dstEIn),
    .i_dstM_in(dstMIn), .o_m_valid(mValid), .o_m_icode(mIcode), .o_m_valE(mValE),
    .o_m_valA(mValA), .o_m_cnd(mCnd), .o_m_dstE(mDstE), .o_m_dstM(mDstM),
    .o_m_err(mErr), .o_cc(cc)
  );

  y86_execute_stage #(.W(16)) dut16 (
    .i_clk(clk), .i_rst_n(rstN), .i_instr_valid(1'b1), .i_stall(1'b0),
    .i_bubble(1'b0), .i_set_cc_en(1'b1), .i_icode(IOPQ), .i_ifun(ALUSUB),
    .i_valA(16'h0001), .i_valB(16'h8000), .i_valC(16'h0000), .i_dstE_in(4'h3),
    .i_dstM_in(RNONE), .o_m_valid(s16Valid), .o_m_icode(s16Icode), .o_m_valE(s16ValE),
    .o_m_valA(s16ValA), .o_m_cnd(s16Cnd), .o_m_dstE(s16DstE), .o_m_dstM(s16DstM),
    .o_m_err(s16Err), .o_cc(s16Cc)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Expected E/M register contents and condition codes
  logic         eValid, eCnd, eErr;
  logic [3:0]   eIcode, eDstE, eDstM;
  logic [W-1:0] eValE, eValA;
  logic [2:0]   eCc;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic refCond(input logic [2:0] c, input logic [3:0] f);
    logic zf, sf, of;
    zf = c[2]; sf = c[1]; of = c[0];
    case (f)
      4'd0:    return 1'b1;
      4'd1:    return (sf != of) || zf;
      4'd2:    return sf != of;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return sf == of;
      4'd6:    return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic loadNop();
    eValid = 1'b0; eIcode = 4'h1; eValE = '0; eValA = '0;
    eCnd = 1'b0; eDstE = 4'hF; eDstM = 4'hF; eErr = 1'b0;
  endtask

  // Signed overflow is judged by whether the exact sum/difference fits in W bits.
  task automatic modelEdge();
    logic [W-1:0]        v;
    logic                cnd, bad, ovf, doCc;
    logic signed [W+1:0] sa, sb, wide, maxS, minS;
    v = '0; cnd = 1'b0; bad = 1'b0; ovf = 1'b0; doCc = 1'b0;
    if (!rstN) begin
      loadNop();
      eCc = 3'b100;
      return;
    end
    if (stall) return;
    if (bubble) begin
      loadNop();
      return;
    end
    sa   = $signed(valA);
    sb   = $signed(valB);
    maxS = {3'b000, {(W-1){1'b1}}};
    minS = -maxS - 1;
    case (icode)
      4'h2: begin v = valA; if (ifun > 4'd6) bad = 1'b1; else cnd = refCond(eCc, ifun); end
      4'h3: v = valC;
      4'h4, 4'h5: v = valB + valC;
      4'h6: begin
        case (ifun)
          4'd0: begin wide = sb + sa; v = wide[W-1:0]; ovf = (wide > maxS) || (wide < minS); end
          4'd1: begin wide = sb - sa; v = wide[W-1:0]; ovf = (wide > maxS) || (wide < minS); end
          4'd2: v = valB & valA;
          4'd3: v = valB ^ valA;
          default: bad = 1'b1;
        endcase
        doCc = !bad && instrValid && setCcEn;
      end
      4'h7: begin if (ifun > 4'd6) bad = 1'b1; else cnd = refCond(eCc, ifun); end
      4'h8, 4'hA: v = valB - 64'd8;
      4'h9, 4'hB: v = valB + 64'd8;
      default: ;
    endcase
    if (bad) begin v = '0; cnd = 1'b0; end
    eValid = instrValid;
    eIcode = icode;
    eValE  = v;
    eValA  = valA;
    eCnd   = cnd;
    eErr   = bad;
    eDstE  = (bad || !instrValid || (icode == 4'h2 && !cnd)) ? 4'hF : dstEIn;
    eDstM  = instrValid ? dstMIn : 4'hF;
    if (doCc) eCc = {(v == '0), v[W-1], ovf};
  endtask

  task automatic applyStimulus(input logic r, input logic iv, input logic st, input logic bu,
                               input logic sc, input logic [3:0] ic, input logic [3:0] fn,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] c, input logic [3:0] de,
                               input logic [3:0] dm);
    rstN = r; instrValid = iv; stall = st; bubble = bu; setCcEn = sc;
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; dstEIn = de; dstMIn = dm;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("m_valid", 64'(mValid), 64'(eValid));
    checkOutput("m_icode", 64'(mIcode), 64'(eIcode));
    checkOutput("m_valE",  mValE,       eValE);
    checkOutput("m_valA",  mValA,       eValA);
    checkOutput("m_cnd",   64'(mCnd),   64'(eCnd));
    checkOutput("m_dstE",  64'(mDstE),  64'(eDstE));
    checkOutput("m_dstM",  64'(mDstM),  64'(eDstM));
    checkOutput("m_err",   64'(mErr),   64'(eErr));
    checkOutput("cc",      64'(cc),     64'(eCc));
  endtask

  // Plain operation with valid=1, set_cc_en=1, no stall/bubble
  task automatic op(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic [W-1:0] c);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ic, fn, a, b, c, 4'h3, 4'h5);
  endtask

  function automatic logic [W-1:0] randVal();
    case ($urandom_range(0, 5))
      0:       return 64'(($urandom_range(0, 16)));
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [3:0] rIc, rFn;
    int         sel;
    loadNop();
    eCc = 3'b100;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h0, '0, '0, '0, 4'h3, 4'h5);
    checkOutput("reset_cc", 64'(cc), 64'h4);
    checkOutput("reset_dstE", 64'(mDstE), 64'hF);

    op(IOPQ, ALUSUB, 64'd1, 64'h8000_0000_0000_0000, '0);
    checkOutput("sub_ovf_valE", mValE, 64'h7FFF_FFFF_FFFF_FFFF);
    checkOutput("sub_ovf_cc", 64'(cc), 64'h1);
    checkOutput("w16_sub_valE", 64'(s16ValE), 64'h7FFF);
    checkOutput("w16_sub_cc", 64'(s16Cc), 64'h1);
    op(IRRMOVQ, C_L, 64'h55, '0, '0);
    checkOutput("cmovl_cnd", 64'(mCnd), 64'h1);
    checkOutput("cmovl_dstE", 64'(mDstE), 64'h3);

    op(IOPQ, ALUADD, -64'sd5, 64'd5, '0);
    checkOutput("add_zero_valE", mValE, 64'h0);
    checkOutput("add_zero_cc", 64'(cc), 64'h4);
    op(IJXX, C_NE, '0, '0, 64'h400);
    checkOutput("jne_cnd", 64'(mCnd), 64'h0);
    op(IRRMOVQ, C_NE, 64'h9, '0, '0);
    checkOutput("cmovne_dstE", 64'(mDstE), 64'hF);

    op(IPUSHQ, 4'h0, 64'h7, 64'h100, '0);
    checkOutput("pushq_valE", mValE, 64'hF8);
    op(IPOPQ, 4'h0, '0, 64'hF8, '0);
    checkOutput("popq_valE", mValE, 64'h100);
    op(IRMMOVQ, 4'h0, 64'h1, 64'h20, 64'h8);
    checkOutput("rmmovq_valE", mValE, 64'h28);
    checkOutput("stack_cc", 64'(cc), 64'h4);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, IOPQ, ALUADD, 64'd3, -64'sd7, '0, 4'h2, 4'hF);
    checkOutput("nocc_valE", mValE, -64'sd4);
    checkOutput("nocc_cc", 64'(cc), 64'h4);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, IOPQ, ALUSUB, 64'd1, 64'd9, '0, 4'h1, 4'h2);
    checkOutput("stall_valE", mValE, -64'sd4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, IOPQ, ALUSUB, 64'd1, 64'd9, '0, 4'h1, 4'h2);
    checkOutput("bubble_icode", 64'(mIcode), 64'h1);

    op(IOPQ, 4'h7, 64'd1, 64'd2, '0);
    checkOutput("opq_bad_err", 64'(mErr), 64'h1);
    checkOutput("opq_bad_cc", 64'(cc), 64'h4);
    op(IJXX, 4'h9, '0, '0, 64'h40);
    checkOutput("jxx_bad_err", 64'(mErr), 64'h1);

    op(IOPQ, ALUXOR, 64'h1, 64'h3, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, IOPQ, ALUADD, 64'h1, 64'h1, '0, 4'h3, 4'h5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, IOPQ, ALUADD, 64'h1, 64'h1, '0, 4'h3, 4'h5);
    checkOutput("rst_in_stall_cc", 64'(cc), 64'h4);
    checkOutput("rst_in_stall_valid", 64'(mValid), 64'h0);

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      rIc = IOPQ;
      else if (sel < 6) rIc = IRRMOVQ;
      else if (sel < 7) rIc = IJXX;
      else              rIc = 4'($urandom_range(0, 15));
      rFn = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      if (rIc == IOPQ && $urandom_range(0, 4) != 0) rFn = 4'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 60) != 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 5) != 0, rIc, rFn, randVal(), randVal(), randVal(),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
